pipe_pattern_engine: RTL and testbench

PIPE_PATTERN_ENGINE -- requirements
Module: pipe_pattern_engine

---
 rtl/pipe_pattern_engine.sv | 219 +++++++++++++++++++++
 tb/tb_pipe_pattern_engine.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_pattern_engine.sv
// Pipe pattern generator and checker built from two identical sequence sources with block throttling.
// Optional build macro PIPE_ENGINE_ERR_CAPTURE_EN adds first-mismatch capture (index, expected, received).

module pipe_pattern_src #(
    parameter int LANES       = 1,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          pattern_i,
    input  logic [31:0]         fixed_pattern_i,
    input  logic                throttle_set_i,
    input  logic [31:0]         throttle_val_i,
    input  logic                strobe_i,
    output logic [LANES*32-1:0] word_o,
    output logic [31:0]         index_o,
    output logic                ready_o,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, BURST = 2'd2} state_t;

    localparam int                 CNT_W = $clog2(BLOCK_WORDS + 1);
    localparam logic [CNT_W-1:0]   FULL  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [31:0]        POLY  = 32'h0040_0007;

    function automatic logic [LANES*32-1:0] seeds();
        logic [LANES*32-1:0] s;
        s = '0;
        for (int k = 0; k < LANES; k++) s[k*32 +: 32] = 32'h0D0C_0B0A + 32'(k);
        return s;
    endfunction

    localparam logic [LANES*32-1:0] SEED = seeds();

    function automatic logic [LANES*32-1:0] make_word(
        input logic [2:0]          pat,
        input logic [31:0]         n,
        input logic [LANES*32-1:0] lfsr,
        input logic [31:0]         fix
    );
        logic [LANES*32-1:0] w;
        logic [4:0]          sh;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            sh = n[4:0] + 5'(k);
            case (pat)
                3'd1:    w[k*32 +: 32] = lfsr[k*32 +: 32];
                3'd2:    w[k*32 +: 32] = 32'd1 << sh;
                3'd3:    w[k*32 +: 32] = fix;
                default: w[k*32 +: 32] = n;
            endcase
        end
        return w;
    endfunction

    logic [31:0]         n_q, n_d;
    logic [LANES*32-1:0] lfsr_q, lfsr_d;
    logic [LANES*32-1:0] word_q;
    state_t              state_q;
    logic [31:0]         rot_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ready_q;

    // Galois step per lane: shift left, fold the x^32 carry back as x^22+x^2+x+1.
    always_comb begin
        n_d    = n_q + 32'd1;
        lfsr_d = lfsr_q;
        for (int k = 0; k < LANES; k++) begin
            lfsr_d[k*32 +: 32] = {lfsr_q[k*32 +: 31], 1'b0} ^ (lfsr_q[k*32+31] ? POLY : 32'h0);
        end
    end

    // The presented word is registered, so a pattern change only shapes words produced afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q    <= '0;
            lfsr_q <= SEED;
            word_q <= make_word(pattern_i, 32'd0, SEED, fixed_pattern_i);
        end else if (strobe_i) begin
            n_q    <= n_d;
            lfsr_q <= lfsr_d;
            word_q <= make_word(pattern_i, n_d, lfsr_d, fixed_pattern_i);
        end
    end

    // Strobes advance the sequence in every state; only READY/BURST count them toward the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rot_q   <= '1;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (throttle_set_i)     rot_q <= throttle_val_i;
            else if (state_q == IDLE) rot_q <= {rot_q[30:0], rot_q[31]};
            case (state_q)
                IDLE: begin
                    if (!throttle_set_i && rot_q[31]) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    if (strobe_i) begin
                        state_q <= BURST;
                        ready_q <= 1'b0;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                BURST: begin
                    if (cnt_q >= FULL) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (strobe_i) begin
                        if (cnt_q == LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign word_o  = word_q;
    assign index_o = n_q;
    assign ready_o = ready_q;
    assign state_o = state_q;
endmodule

module pipe_pattern_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            pattern,
    input  logic [31:0]           fixed_pattern,
    input  logic                  throttle_set,
    input  logic [31:0]           throttle_val,
    input  logic                  gen_read,
    output logic [DATA_WIDTH-1:0] gen_data,
    output logic                  gen_ready,
    input  logic                  chk_write,
    input  logic [DATA_WIDTH-1:0] chk_data,
    output logic                  chk_ready,
    output logic [31:0]           error_count,
    output logic [31:0]           err_index,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic [DATA_WIDTH-1:0] err_received
);
    localparam int LANES = DATA_WIDTH / 32;

    logic [DATA_WIDTH-1:0] exp_word;
    logic [31:0]           gen_index, chk_index;
    logic [1:0]            gen_state, chk_state;
    logic                  mismatch;
    logic [31:0]           err_cnt_q;
    logic                  unused_ok;

    pipe_pattern_src #(.LANES(LANES), .BLOCK_WORDS(BLOCK_WORDS)) gen_src (
        .clk(clk), .reset(reset), .pattern_i(pattern), .fixed_pattern_i(fixed_pattern),
        .throttle_set_i(throttle_set), .throttle_val_i(throttle_val), .strobe_i(gen_read),
        .word_o(gen_data), .index_o(gen_index), .ready_o(gen_ready), .state_o(gen_state)
    );

    pipe_pattern_src #(.LANES(LANES), .BLOCK_WORDS(BLOCK_WORDS)) chk_src (
        .clk(clk), .reset(reset), .pattern_i(pattern), .fixed_pattern_i(fixed_pattern),
        .throttle_set_i(throttle_set), .throttle_val_i(throttle_val), .strobe_i(chk_write),
        .word_o(exp_word), .index_o(chk_index), .ready_o(chk_ready), .state_o(chk_state)
    );

    assign mismatch = chk_write && (chk_data != exp_word);

    always_ff @(posedge clk) begin
        if (reset)                           err_cnt_q <= '0;
        else if (mismatch && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 32'd1;
    end

    assign error_count = err_cnt_q;

`ifdef PIPE_ENGINE_ERR_CAPTURE_EN
    logic                  seen_q;
    logic [31:0]           idx_q;
    logic [DATA_WIDTH-1:0] exp_q, rcv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q <= 1'b0;
            idx_q  <= '0;
            exp_q  <= '0;
            rcv_q  <= '0;
        end else if (mismatch && !seen_q) begin
            seen_q <= 1'b1;
            idx_q  <= chk_index;
            exp_q  <= exp_word;
            rcv_q  <= chk_data;
        end
    end

    assign err_index    = idx_q;
    assign err_expected = exp_q;
    assign err_received = rcv_q;
    assign unused_ok    = ^{gen_index, gen_state, chk_state};
`else
    assign err_index    = '0;
    assign err_expected = '0;
    assign err_received = '0;
    assign unused_ok    = ^{gen_index, gen_state, chk_state, chk_index};
`endif
endmodule

// File: tb/tb_pipe_pattern_engine.sv
// Bench for pipe_pattern_engine (64-bit, 4-word blocks): vector table, random loopback against a
// word-level reference model, and hand sequences for throttle, reset and saturation corners.

module tb_pipe_pattern_engine;
    localparam int DW    = 64;
    localparam int LANES = DW / 32;
    localparam int BW    = 4;
`ifdef PIPE_ENGINE_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, throttle_set, gen_read, chk_write;
    logic [2:0]    pattern;
    logic [31:0]   fixed_pattern, throttle_val;
    logic [DW-1:0] chk_data, gen_data, err_expected, err_received;
    logic          gen_ready, chk_ready;
    logic [31:0]   error_count, err_index;

    always #5 clk = ~clk;

    pipe_pattern_engine #(.DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
        .clk(clk), .reset(reset), .pattern(pattern), .fixed_pattern(fixed_pattern),
        .throttle_set(throttle_set), .throttle_val(throttle_val),
        .gen_read(gen_read), .gen_data(gen_data), .gen_ready(gen_ready),
        .chk_write(chk_write), .chk_data(chk_data), .chk_ready(chk_ready),
        .error_count(error_count), .err_index(err_index),
        .err_expected(err_expected), .err_received(err_received)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model: word number, per-lane LFSR value, and error bookkeeping.
    logic [31:0]             gm_n, cm_n, m_errs, m_idx;
    logic [LANES-1:0][31:0]  gm_l, cm_l;
    logic [DW-1:0]           gm_word, cm_word, m_exp, m_rcv;
    bit                      m_seen;

    // Multiply by x in GF(2)[x] modulo x^32+x^22+x^2+x+1.
    function automatic logic [31:0] galois(input logic [31:0] s);
        logic [32:0] t;
        t = {s, 1'b0};
        if (t[32]) t = t ^ 33'h1_0040_0007;
        return t[31:0];
    endfunction

    function automatic logic [DW-1:0] ref_word(input logic [2:0] p, input logic [31:0] n,
                                               input logic [LANES-1:0][31:0] l, input logic [31:0] f);
        logic [DW-1:0] w;
        int unsigned   sh;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            sh = (n + 32'(k)) % 32;
            if (p == 3'd1)      w[k*32 +: 32] = l[k];
            else if (p == 3'd2) w[k*32 +: 32] = 32'd1 << sh;
            else if (p == 3'd3) w[k*32 +: 32] = f;
            else                w[k*32 +: 32] = n;
        end
        return w;
    endfunction

    task automatic model_reset(input logic [2:0] p, input logic [31:0] f);
        gm_n = 0;
        cm_n = 0;
        for (int k = 0; k < LANES; k++) begin
            gm_l[k] = 32'h0D0C_0B0A + 32'(k);
            cm_l[k] = 32'h0D0C_0B0A + 32'(k);
        end
        gm_word = ref_word(p, 0, gm_l, f);
        cm_word = gm_word;
        m_errs = 0; m_seen = 0; m_idx = 0; m_exp = '0; m_rcv = '0;
    endtask

    // One clock: inputs driven before the edge feed both DUT and model; outputs settle by the negedge.
    task automatic step();
        logic [2:0]    p;
        logic [31:0]   f;
        logic          rs, gr, cw;
        logic [DW-1:0] cd;
        p = pattern; f = fixed_pattern; rs = reset; gr = gen_read; cw = chk_write; cd = chk_data;
        @(posedge clk);
        if (rs) begin
            model_reset(p, f);
        end else begin
            if (gr) begin
                gm_n++;
                for (int k = 0; k < LANES; k++) gm_l[k] = galois(gm_l[k]);
                gm_word = ref_word(p, gm_n, gm_l, f);
            end
            if (cw) begin
                if (cd !== cm_word) begin
                    if (m_errs != 32'hFFFF_FFFF) m_errs++;
                    if (!m_seen) begin
                        m_seen = 1; m_idx = cm_n; m_exp = cm_word; m_rcv = cd;
                    end
                end
                cm_n++;
                for (int k = 0; k < LANES; k++) cm_l[k] = galois(cm_l[k]);
                cm_word = ref_word(p, cm_n, cm_l, f);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1; gen_read = 0; chk_write = 0; throttle_set = 0;
        step();
        step();
        reset = 0;
    endtask

    task automatic strobe_gen(input int count);
        for (int i = 0; i < count; i++) begin
            gen_read = 1;
            step();
        end
        gen_read = 0;
    endtask

    task automatic wait_gen_ready(output int edges);
        edges = 0;
        while (!gen_ready && edges < 100) begin
            step();
            edges++;
        end
    endtask

    task automatic check_capture(input string tag, input logic [31:0] idx);
        check({tag, "_err_index"}, err_index, CAP ? idx : 32'd0);
        check({tag, "_err_expected"}, err_expected, CAP ? m_exp : '0);
        check({tag, "_err_received"}, err_received, CAP ? m_rcv : '0);
    endtask

    // Loopback gen_data -> chk_data; a word whose checker index equals bad0/bad1 gets one bit flipped.
    task automatic loopback(input int words, input bit mix, input logic [31:0] bad0, input logic [31:0] bad1);
        int done, cyc;
        bit r;
        done = 0; cyc = 0;
        while (done < words && cyc < words * 8) begin
            r = ($urandom_range(0, 3) != 0);
            if (mix) pattern = 3'($urandom_range(0, 7));
            fixed_pattern = $urandom;
            gen_read = r; chk_write = r; chk_data = gen_data;
            if (r && (cm_n == bad0 || cm_n == bad1))
                chk_data = gen_data ^ (DW'(1) << $urandom_range(0, DW - 1));
            step();
            cyc++;
            if (r) done++;
            check("gen_word", gen_data, gm_word);
        end
        gen_read = 0; chk_write = 0;
        check("loop_words", DW'(done), DW'(words));
    endtask

    typedef struct {
        logic [2:0]  pat;
        logic [31:0] fix;
        int          reads;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        bit   seen_ready;
        reset = 1; pattern = 0; fixed_pattern = 0; throttle_set = 0; throttle_val = 0;
        gen_read = 0; chk_write = 0; chk_data = '0;

        vecs[0]  = '{3'd0, 32'h0, 0, 32'h0, 32'h0};
        vecs[1]  = '{3'd0, 32'h0, 4, 32'h4, 32'h4};
        vecs[2]  = '{3'd1, 32'h0, 0, 32'h0D0C_0B0A, 32'h0D0C_0B0B};
        vecs[3]  = '{3'd1, 32'h0, 1, 32'h1A18_1614, 32'h1A18_1616};
        vecs[4]  = '{3'd1, 32'h0, 2, 32'h3430_2C28, 32'h3430_2C2C};
        vecs[5]  = '{3'd1, 32'h0, 5, 32'hA1C1_6147, 32'hA1C1_6167};
        vecs[6]  = '{3'd2, 32'h0, 0, 32'h1, 32'h2};
        vecs[7]  = '{3'd2, 32'h0, 5, 32'h20, 32'h40};
        vecs[8]  = '{3'd2, 32'h0, 31, 32'h8000_0000, 32'h1};
        vecs[9]  = '{3'd3, 32'hA5A5_5A5A, 3, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
        vecs[10] = '{3'd5, 32'h0, 7, 32'h7, 32'h7};
        vecs[11] = '{3'd7, 32'h0, 0, 32'h0, 32'h0};

        // Reset state
        do_reset();
        check("rst_gen_ready", gen_ready, 0);
        check("rst_chk_ready", chk_ready, 0);
        check("rst_error_count", error_count, 0);
        check_capture("rst", 32'd0);

        // Counter sequence 0..4 on successive reads
        check("cnt_word0", gen_data, {32'd0, 32'd0});
        for (int i = 1; i <= 4; i++) begin
            strobe_gen(1);
            check($sformatf("cnt_word%0d", i), gen_data, {32'(i), 32'(i)});
        end

        // Vector table
        for (int v = 0; v < 12; v++) begin
            pattern = vecs[v].pat;
            fixed_pattern = vecs[v].fix;
            do_reset();
            strobe_gen(vecs[v].reads);
            check($sformatf("vec%0d", v), gen_data, {vecs[v].exp1, vecs[v].exp0});
        end

        // Clean loopback in each pattern, then with the pattern changing every cycle
        for (int p = 0; p < 4; p++) begin
            pattern = 3'(p);
            do_reset();
            loopback(1000, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            check($sformatf("loop_err_p%0d", p), error_count, 32'd0);
        end
        do_reset();
        loopback(300, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("loop_err_mixed", error_count, 32'd0);

        // Corrupt word 10, then word 20: capture must keep the first
        pattern = 3'd1;
        do_reset();
        loopback(15, 0, 32'd10, 32'hFFFF_FFFF);
        check("corrupt_count1", error_count, 32'd1);
        check_capture("corrupt1", 32'd10);
        loopback(15, 0, 32'd20, 32'hFFFF_FFFF);
        check("corrupt_count2", error_count, 32'd2);
        check_capture("corrupt2", 32'd10);
        do_reset();
        check("rst2_error_count", error_count, 32'd0);
        check_capture("rst2", 32'd0);

        // Independent random strobes, random data, random pattern
        for (int i = 0; i < 400; i++) begin
            gen_read = 1'($urandom_range(0, 1));
            chk_write = 1'($urandom_range(0, 1));
            pattern = 3'($urandom_range(0, 7));
            fixed_pattern = $urandom;
            chk_data = ($urandom_range(0, 1) != 0) ? cm_word : {$urandom, $urandom};
            step();
            check("rand_gen_word", gen_data, gm_word);
            check("rand_error_count", error_count, m_errs);
        end
        gen_read = 0; chk_write = 0;
        check_capture("rand", m_idx);

        // Saturation from a preloaded count
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_cnt_q;
        m_errs = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            chk_write = 1; chk_data = ~cm_word;
            step();
            check($sformatf("sat_count%0d", i), error_count, 32'hFFFF_FFFF);
        end
        chk_write = 0;

        // Throttle period with a single set bit and 4-word blocks
        pattern = 3'd0;
        do_reset();
        throttle_val = 32'h8000_0000; throttle_set = 1;
        step();
        throttle_set = 0;
        check("thr_after_load", gen_ready, 0);
        wait_gen_ready(edges);
        check("thr_gap0", DW'(edges), DW'(1));
        check("thr_chk_ready", chk_ready, 1);
        for (int b = 0; b < 2; b++) begin
            strobe_gen(1);
            check($sformatf("thr_fall%0d", b), gen_ready, 0);
            strobe_gen(3);
            wait_gen_ready(edges);
            check($sformatf("thr_gap%0d", b + 1), DW'(edges), DW'(32));
            check($sformatf("thr_chk_hold%0d", b), chk_ready, 1);
        end

        // Reset mid-burst, with strobes and throttle_set asserted alongside
        do_reset();
        step();
        check("mid_ready", gen_ready, 1);
        strobe_gen(2);
        reset = 1; gen_read = 1; chk_write = 1; throttle_set = 1; throttle_val = 32'h0;
        step();
        reset = 0; gen_read = 0; chk_write = 0; throttle_set = 0;
        check("mid_rst_ready", gen_ready, 0);
        check("mid_rst_chk_ready", chk_ready, 0);
        check("mid_rst_word", gen_data, '0);
        step();
        check("mid_ready_again", gen_ready, 1);
        strobe_gen(3);
        step();
        step();
        check("mid_still_burst", gen_ready, 0);
        strobe_gen(1);
        step();
        check("mid_burst_done", gen_ready, 1);

        // Zero mask: ready never rises
        do_reset();
        throttle_val = 32'h0; throttle_set = 1;
        step();
        throttle_set = 0;
        seen_ready = 0;
        for (int i = 0; i < 100; i++) begin
            gen_read = 1'($urandom_range(0, 1));
            chk_write = 1'($urandom_range(0, 1));
            chk_data = cm_word;
            step();
            if (gen_ready || chk_ready) seen_ready = 1;
        end
        gen_read = 0; chk_write = 0;
        check("zero_mask_ready", DW'(seen_ready), '0);
        check("zero_mask_errors", error_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
